// File: rtl/trace_commit_queue_if.sv
// Commit-record handshake into the trace queue and the registered record it emits to the trace sink.
interface trace_commit_queue_if #(
  parameter int unsigned ARCH_LEN  = 32,
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned REG_BITS  = 8
);
  localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS);
  localparam int unsigned DATA_BITS    = NUM_LANES * ARCH_LEN;

  logic                    in_valid;
  logic                    in_ready;
  logic [ARCH_LEN-1:0]     in_pc;
  logic [WARP_ID_BITS-1:0] in_warpId;
  logic [NUM_LANES-1:0]    in_tmask;
  logic                    in_regs_0_enable;
  logic [REG_BITS-1:0]     in_regs_0_address;
  logic [DATA_BITS-1:0]    in_regs_0_data;
  logic                    in_regs_1_enable;
  logic [REG_BITS-1:0]     in_regs_1_address;
  logic [DATA_BITS-1:0]    in_regs_1_data;
  logic                    in_regs_2_enable;
  logic [REG_BITS-1:0]     in_regs_2_address;
  logic [DATA_BITS-1:0]    in_regs_2_data;
  logic                    trace_pause;

  logic                    inst_valid;
  logic [ARCH_LEN-1:0]     inst_pc;
  logic [WARP_ID_BITS-1:0] inst_warpId;
  logic [NUM_LANES-1:0]    inst_tmask;
  logic                    inst_regs_0_enable;
  logic [REG_BITS-1:0]     inst_regs_0_address;
  logic [DATA_BITS-1:0]    inst_regs_0_data;
  logic                    inst_regs_1_enable;
  logic [REG_BITS-1:0]     inst_regs_1_address;
  logic [DATA_BITS-1:0]    inst_regs_1_data;
  logic                    inst_regs_2_enable;
  logic [REG_BITS-1:0]     inst_regs_2_address;
  logic [DATA_BITS-1:0]    inst_regs_2_data;

  modport master (
    output in_valid, in_pc, in_warpId, in_tmask,
           in_regs_0_enable, in_regs_0_address, in_regs_0_data,
           in_regs_1_enable, in_regs_1_address, in_regs_1_data,
           in_regs_2_enable, in_regs_2_address, in_regs_2_data,
           trace_pause,
    input  in_ready, inst_valid, inst_pc, inst_warpId, inst_tmask,
           inst_regs_0_enable, inst_regs_0_address, inst_regs_0_data,
           inst_regs_1_enable, inst_regs_1_address, inst_regs_1_data,
           inst_regs_2_enable, inst_regs_2_address, inst_regs_2_data
  );

  modport slave (
    input  in_valid, in_pc, in_warpId, in_tmask,
           in_regs_0_enable, in_regs_0_address, in_regs_0_data,
           in_regs_1_enable, in_regs_1_address, in_regs_1_data,
           in_regs_2_enable, in_regs_2_address, in_regs_2_data,
           trace_pause,
    output in_ready, inst_valid, inst_pc, inst_warpId, inst_tmask,
           inst_regs_0_enable, inst_regs_0_address, inst_regs_0_data,
           inst_regs_1_enable, inst_regs_1_address, inst_regs_1_data,
           inst_regs_2_enable, inst_regs_2_address, inst_regs_2_data
  );
endinterface

// File: rtl/trace_commit_queue.sv
// Elastic FIFO between commit and the trace sink; emits one registered record per unpaused cycle.
// Define TRACE_COMMIT_DROP_EN to never stall the core: records that find no room are counted and dropped.
module trace_commit_queue #(
  parameter int unsigned ARCH_LEN  = 32,
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned REG_BITS  = 8,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  trace_commit_queue_if.slave bus,
  output logic [CNT_BITS-1:0] count,
  output logic [31:0]         drop_count
);
  localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS);
  localparam int unsigned PTR_BITS     = $clog2(DEPTH);
  localparam int unsigned DATA_BITS    = NUM_LANES * ARCH_LEN;
  localparam int unsigned SLOT_BITS    = 1 + REG_BITS + DATA_BITS;
  localparam int unsigned REC_W        = ARCH_LEN + WARP_ID_BITS + NUM_LANES + 3 * SLOT_BITS;

  logic [REC_W-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [REC_W-1:0]    in_rec;
  logic [REC_W-1:0]    out_rec;
  logic                full;
  logic                fire;
  logic                pop;
  logic                bypass;
  logic                push;

  assign in_rec = {bus.in_pc, bus.in_warpId, bus.in_tmask,
                   bus.in_regs_0_enable, bus.in_regs_0_address, bus.in_regs_0_data,
                   bus.in_regs_1_enable, bus.in_regs_1_address, bus.in_regs_1_data,
                   bus.in_regs_2_enable, bus.in_regs_2_address, bus.in_regs_2_data};

  assign {bus.inst_pc, bus.inst_warpId, bus.inst_tmask,
          bus.inst_regs_0_enable, bus.inst_regs_0_address, bus.inst_regs_0_data,
          bus.inst_regs_1_enable, bus.inst_regs_1_address, bus.inst_regs_1_data,
          bus.inst_regs_2_enable, bus.inst_regs_2_address, bus.inst_regs_2_data} = out_rec;

  assign full = (count == CNT_BITS'(DEPTH));

`ifdef TRACE_COMMIT_DROP_EN
  logic drop;
  assign bus.in_ready = !reset;
`else
  assign bus.in_ready = !full && !reset;
`endif

  // Head pops whenever unpaused; an input only bypasses when nothing is queued ahead of it.
  always_comb begin
    fire   = bus.in_valid && bus.in_ready;
    pop    = !bus.trace_pause && (count != '0);
    bypass = !bus.trace_pause && (count == '0) && fire;
`ifdef TRACE_COMMIT_DROP_EN
    push   = fire && !bypass && (!full || pop);
    drop   = fire && !bypass && full && !pop;
`else
    push   = fire && !bypass;
`endif
  end

  // Storage array carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_rec;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      bus.inst_valid <= 1'b0;
      out_rec        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      if (push && !pop)      count <= count + CNT_BITS'(1);
      else if (pop && !push) count <= count - CNT_BITS'(1);

      // Data fields hold their last value whenever no record is emitted.
      if (pop) begin
        out_rec        <= mem[rd_ptr];
        bus.inst_valid <= 1'b1;
      end else if (bypass) begin
        out_rec        <= in_rec;
        bus.inst_valid <= 1'b1;
      end else begin
        bus.inst_valid <= 1'b0;
      end
    end
  end

`ifdef TRACE_COMMIT_DROP_EN
  always_ff @(posedge clock) begin
    if (reset)                       drop_count <= '0;
    else if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_trace_commit_queue.sv
// Directed bench for trace_commit_queue: vector table plus a hand-written single-record bypass sequence.
module tb_trace_commit_queue;
  localparam int unsigned ARCH_LEN     = 32;
  localparam int unsigned NUM_WARPS    = 8;
  localparam int unsigned NUM_LANES    = 16;
  localparam int unsigned REG_BITS     = 8;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned CNT_BITS     = $clog2(DEPTH + 1);
  localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS);
  localparam int unsigned DATA_BITS    = NUM_LANES * ARCH_LEN;
  localparam int unsigned REC_W        = ARCH_LEN + WARP_ID_BITS + NUM_LANES + 3 * (1 + REG_BITS + DATA_BITS);

`ifdef TRACE_COMMIT_DROP_EN
  localparam bit DROP_MODE = 1'b1;
`else
  localparam bit DROP_MODE = 1'b0;
`endif
  localparam logic        RDY_FULL = DROP_MODE;
  localparam logic [31:0] D1       = DROP_MODE ? 32'd1 : 32'd0;

  logic                clock = 1'b0;
  logic                reset;
  logic [CNT_BITS-1:0] count;
  logic [31:0]         drop_count;
  int                  tests = 0;
  int                  fails = 0;

  always #5 clock = ~clock;

  trace_commit_queue_if #(.ARCH_LEN(ARCH_LEN), .NUM_WARPS(NUM_WARPS),
                          .NUM_LANES(NUM_LANES), .REG_BITS(REG_BITS)) bus ();

  trace_commit_queue #(.ARCH_LEN(ARCH_LEN), .NUM_WARPS(NUM_WARPS), .NUM_LANES(NUM_LANES),
                       .REG_BITS(REG_BITS), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .count      (count),
    .drop_count (drop_count)
  );

  typedef struct {
    logic                rst;
    logic                vld;
    logic                pause;
    logic [31:0]         pc;
    logic                e_valid;
    logic [31:0]         e_pc;
    logic [CNT_BITS-1:0] e_count;
    logic                e_ready;
    logic [31:0]         e_drop;
  } vec_t;

  vec_t vecs[$];

  // Deterministic record derived from its PC; PC 0 yields an all-zero record.
  function automatic logic [REC_W-1:0] gen_rec(input logic [31:0] pc);
    logic [DATA_BITS-1:0] d [3];
    logic [REG_BITS-1:0]  a [3];
    logic                 en [3];
    for (int k = 0; k < 3; k++) begin
      en[k] = ^(pc >> k);
      a[k]  = REG_BITS'(32'(pc[7:0] ^ pc[15:8]) * 32'(k + 1));
      for (int g = 0; g < int'(NUM_LANES); g++)
        d[k][ARCH_LEN*g +: ARCH_LEN] = ARCH_LEN'(pc * 32'(g + 1 + 16 * k));
    end
    return {ARCH_LEN'(pc), WARP_ID_BITS'(pc), NUM_LANES'(pc[15:0] ^ {pc[7:0], pc[7:0]}),
            en[0], a[0], d[0], en[1], a[1], d[1], en[2], a[2], d[2]};
  endfunction

  function automatic logic [REC_W-1:0] get_out();
    return {bus.inst_pc, bus.inst_warpId, bus.inst_tmask,
            bus.inst_regs_0_enable, bus.inst_regs_0_address, bus.inst_regs_0_data,
            bus.inst_regs_1_enable, bus.inst_regs_1_address, bus.inst_regs_1_data,
            bus.inst_regs_2_enable, bus.inst_regs_2_address, bus.inst_regs_2_data};
  endfunction

  function automatic logic [31:0] fold(input logic [REC_W-1:0] r);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < int'(REC_W); i++) s[i % 32] = s[i % 32] ^ r[i];
    return s;
  endfunction

  task automatic set_inputs(input logic [REC_W-1:0] r);
    {bus.in_pc, bus.in_warpId, bus.in_tmask,
     bus.in_regs_0_enable, bus.in_regs_0_address, bus.in_regs_0_data,
     bus.in_regs_1_enable, bus.in_regs_1_address, bus.in_regs_1_data,
     bus.in_regs_2_enable, bus.in_regs_2_address, bus.in_regs_2_data} = r;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: record checksum got %08h, expected %08h", name, fold(act), fold(exp));
    end
  endtask

  task automatic add(input logic rst, input logic vld, input logic pause, input logic [31:0] pc,
                     input logic ev, input logic [31:0] epc, input int ecnt,
                     input logic erdy, input logic [31:0] edrop);
    vec_t v;
    v.rst = rst; v.vld = vld; v.pause = pause; v.pc = pc;
    v.e_valid = ev; v.e_pc = epc; v.e_count = CNT_BITS'(ecnt); v.e_ready = erdy; v.e_drop = edrop;
    vecs.push_back(v);
  endtask

  initial begin
    logic [DATA_BITS-1:0] d0;
    logic [REC_W-1:0]     r0;

    // Reset and idle.
    add(1, 0, 0, 0,      0, 0, 0, 0, 0);
    add(0, 0, 0, 0,      0, 0, 0, 1, 0);
    // Eight back-to-back bypassed records.
    for (int i = 0; i < 8; i++) add(0, 1, 0, 32'h100 + i, 1, 32'h100 + i, 0, 1, 0);
    add(0, 0, 0, 32'h1ff, 0, 32'h107, 0, 1, 0);
    // Paused: fill to DEPTH, fifth record stalls (or drops).
    for (int i = 0; i < 4; i++) add(0, 1, 1, 32'h200 + i, 0, 32'h107, i + 1, (i == 3) ? RDY_FULL : 1'b1, 0);
    add(0, 1, 1, 32'h204, 0, 32'h107, 4, RDY_FULL, D1);
    if (!DROP_MODE) begin
      add(0, 1, 0, 32'h204, 1, 32'h200, 3, 1, 0);
      add(0, 1, 0, 32'h204, 1, 32'h201, 3, 1, 0);
      add(0, 0, 0, 0,       1, 32'h202, 2, 1, 0);
      add(0, 0, 0, 0,       1, 32'h203, 1, 1, 0);
      add(0, 0, 0, 0,       1, 32'h204, 0, 1, 0);
      add(0, 0, 0, 0,       0, 32'h204, 0, 1, 0);
    end else begin
      add(0, 0, 0, 0, 1, 32'h200, 3, 1, 1);
      add(0, 0, 0, 0, 1, 32'h201, 2, 1, 1);
      add(0, 0, 0, 0, 1, 32'h202, 1, 1, 1);
      add(0, 0, 0, 0, 1, 32'h203, 0, 1, 1);
      add(0, 0, 0, 0, 0, 32'h203, 0, 1, 1);
      add(0, 0, 0, 0, 0, 32'h203, 0, 1, 1);
    end
    // Full queue released with a new input on the same edge.
    for (int i = 0; i < 4; i++)
      add(0, 1, 1, 32'h300 + i, 0, DROP_MODE ? 32'h203 : 32'h204, i + 1, (i == 3) ? RDY_FULL : 1'b1, D1);
    if (!DROP_MODE) begin
      add(0, 1, 0, 32'h304, 1, 32'h300, 3, 1, 0);
      add(0, 1, 0, 32'h304, 1, 32'h301, 3, 1, 0);
    end else begin
      add(0, 1, 0, 32'h304, 1, 32'h300, 4, 1, 1);
      add(0, 0, 0, 0,       1, 32'h301, 3, 1, 1);
    end
    add(0, 0, 0, 0, 1, 32'h302, 2, 1, D1);
    add(0, 0, 0, 0, 1, 32'h303, 1, 1, D1);
    add(0, 0, 0, 0, 1, 32'h304, 0, 1, D1);
    add(0, 0, 0, 0, 0, 32'h304, 0, 1, D1);
    // Reset with three queued records; nothing stale may appear afterwards.
    for (int i = 0; i < 3; i++) add(0, 1, 1, 32'h400 + i, 0, 32'h304, i + 1, 1, D1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 32'h500, 1, 32'h500, 0, 1, 0);

    // Hand-written: reset state, then one bypassed record with lane g = g in slot 0.
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.trace_pause = 1'b0;
    set_inputs('0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset inst_valid", 32'(bus.inst_valid), 0);
    chk("reset count", 32'(count), 0);
    chk("reset in_ready", 32'(bus.in_ready), 0);
    chk_rec("reset fields", get_out(), '0);
    reset = 1'b0;
    for (int g = 0; g < int'(NUM_LANES); g++) d0[ARCH_LEN*g +: ARCH_LEN] = ARCH_LEN'(g);
    r0 = {ARCH_LEN'(32'h8000_0000), WARP_ID_BITS'(3), NUM_LANES'(16'hFFFF),
          1'b1, REG_BITS'(5), d0,
          1'b0, REG_BITS'(0), {DATA_BITS{1'b0}},
          1'b0, REG_BITS'(0), {DATA_BITS{1'b0}}};
    set_inputs(r0);
    bus.in_valid = 1'b1;
    #1;
    chk("single in_ready", 32'(bus.in_ready), 1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    chk("single inst_valid", 32'(bus.inst_valid), 1);
    chk("single inst_pc", bus.inst_pc, 32'h8000_0000);
    chk("single inst_warpId", 32'(bus.inst_warpId), 3);
    chk("single inst_tmask", 32'(bus.inst_tmask), 32'hFFFF);
    chk_rec("single fields", get_out(), r0);
    chk("single count", 32'(count), 0);
    @(posedge clock);
    #1;
    chk("single pulse ends", 32'(bus.inst_valid), 0);
    chk_rec("single fields held", get_out(), r0);

    // Vector table.
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      bus.in_valid = vecs[i].vld;
      bus.trace_pause = vecs[i].pause;
      set_inputs(gen_rec(vecs[i].pc));
      @(posedge clock);
      #1;
      chk($sformatf("row %0d inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].e_valid));
      chk($sformatf("row %0d inst_pc", i), bus.inst_pc, vecs[i].e_pc);
      chk($sformatf("row %0d count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("row %0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ready));
      chk($sformatf("row %0d drop_count", i), drop_count, vecs[i].e_drop);
      chk_rec($sformatf("row %0d fields", i), get_out(), gen_rec(vecs[i].e_pc));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
